// File: rtl/img_window_pkg.sv
// Shared encodings and default widths for the image window path.
// Used by the frame sequencer and the 3-line window buffer.
package img_window_pkg;

  localparam int DW_DEF  = 24;
  localparam int W_W_DEF = 11;
  localparam int H_W_DEF = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/img_pos_counter.sv
// Column/row position counter with clear, enable and W/H wrap.
// col/row/last describe the current beat; clr makes it (0,0).
module img_pos_counter
  import img_window_pkg::*;
#(
  parameter int W_W = W_W_DEF,
  parameter int H_W = H_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic [W_W-1:0] width,
  input  logic [H_W-1:0] height,
  output logic [W_W-1:0] col,
  output logic [H_W-1:0] row,
  output logic           last
);

  logic [W_W-1:0] col_q;
  logic [H_W-1:0] row_q;
  logic           col_end;
  logic           row_end;

  always_comb begin
    col     = clr ? '0 : col_q;
    row     = clr ? '0 : row_q;
    col_end = (col == width - W_W'(1));
    row_end = (row == height - H_W'(1));
    last    = col_end && row_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row + H_W'(1);
      end else begin
        col_q <= col + W_W'(1);
        row_q <= row;
      end
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

endmodule

// File: rtl/img_window_ctrl.sv
// Frame sequencer ahead of the 3-line window buffer: forwards pixels,
// appends one zero flush row, tags centre row/col, flags errors.
module img_window_ctrl
  import img_window_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int H_W       = H_W_DEF,
  parameter int FLUSH_GAP = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W_W-1:0] img_width,
  input  logic [H_W-1:0] img_height,
  input  logic           sof_i,
  input  logic [DW-1:0]  pix_i,
  input  logic           pix_valid_i,
  output logic [DW-1:0]  lb_data_o,
  output logic           lb_valid_o,
  output logic           ctr_valid_o,
  output logic [H_W-1:0] ctr_row_o,
  output logic [W_W-1:0] ctr_col_o,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic [1:0]     err_o
);

  localparam int GW = (FLUSH_GAP > 0) ? $clog2(FLUSH_GAP + 1) : 1;

  state_t         state;
  state_t         nxt;
  logic [W_W-1:0] w_q;
  logic [H_W-1:0] h_q;
  logic [W_W-1:0] cfg_w;
  logic [H_W-1:0] cfg_h;
  logic [GW-1:0]  gap_q;
  logic           pend_q;

  logic           start;
  logic           load;
  logic           acc;
  logic           fl_beat;
  logic           fl_clr;
  logic [W_W-1:0] in_col;
  logic [H_W-1:0] in_row;
  logic           in_last;
  logic [W_W-1:0] fl_col;
  logic [H_W-1:0] fl_row;
  logic           fl_last;
  logic           unused_fl;

  assign unused_fl = ^fl_row;

  // A start request only becomes a frame if the new geometry is non-empty.
  always_comb begin
    start   = (sof_i && state != FLUSH) || (state == DONE && pend_q);
    load    = start && (|img_width) && (|img_height);
    cfg_w   = load ? img_width : w_q;
    cfg_h   = load ? img_height : h_q;
    acc     = pix_valid_i && (load || (state == RUN && !sof_i));
    fl_clr  = acc && in_last;
    fl_beat = (state == FLUSH) && (gap_q == '0);
    nxt     = state;
    case (state)
      IDLE:    nxt = state;
      RUN:     if (sof_i) nxt = IDLE;
               else if (fl_clr) nxt = FLUSH;
      FLUSH:   if (fl_beat && fl_last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (load) nxt = fl_clr ? FLUSH : RUN;
  end

  img_pos_counter #(.W_W(W_W), .H_W(H_W)) u_in_pos (
    .clk    (clk),
    .reset  (reset),
    .clr    (load),
    .en     (acc),
    .width  (cfg_w),
    .height (cfg_h),
    .col    (in_col),
    .row    (in_row),
    .last   (in_last)
  );

  img_pos_counter #(.W_W(W_W), .H_W(H_W)) u_fl_pos (
    .clk    (clk),
    .reset  (reset),
    .clr    (fl_clr),
    .en     (fl_beat),
    .width  (w_q),
    .height (H_W'(1)),
    .col    (fl_col),
    .row    (fl_row),
    .last   (fl_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      gap_q        <= '0;
      pend_q       <= 1'b0;
      lb_data_o    <= '0;
      lb_valid_o   <= 1'b0;
      ctr_valid_o  <= 1'b0;
      ctr_row_o    <= '0;
      ctr_col_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= '0;
    end else begin
      state        <= nxt;
      busy_o       <= (nxt == RUN) || (nxt == FLUSH);
      frame_done_o <= (state == DONE);
      lb_valid_o   <= acc || fl_beat;
      lb_data_o    <= acc ? pix_i : '0;
      ctr_valid_o  <= (acc && in_row != '0) || fl_beat;
      unique case (1'b1)
        acc: begin
          ctr_row_o <= (in_row != '0) ? in_row - H_W'(1) : '0;
          ctr_col_o <= in_col;
        end
        fl_beat: begin
          ctr_row_o <= h_q - H_W'(1);
          ctr_col_o <= fl_col;
        end
        default: begin
          ctr_row_o <= '0;
          ctr_col_o <= '0;
        end
      endcase
      if (load) begin
        w_q <= img_width;
        h_q <= img_height;
      end
      if (state == DONE) pend_q <= 1'b0;
      else if (state == FLUSH && sof_i) pend_q <= 1'b1;
      if (state == RUN && sof_i) err_o[0] <= 1'b1;
      if (state == FLUSH && pix_valid_i) err_o[1] <= 1'b1;
      if (fl_clr) gap_q <= '0;
      else if (fl_beat) gap_q <= GW'(FLUSH_GAP);
      else if (gap_q != '0) gap_q <= gap_q - GW'(1);
    end
  end

endmodule

// File: tb/tb_img_window_ctrl.sv
// Directed bench for img_window_ctrl: normal frame, async reset, short
// frame, flush-time pixel/sof, zero height and spaced flush beats.
module tb_img_window_ctrl;

  typedef struct packed {
    logic [23:0] d;
    logic        cv;
    logic [9:0]  r;
    logic [10:0] c;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [10:0] img_width = '0;
  logic [9:0]  img_height = '0;
  logic [23:0] pix_i = '0;

  logic [23:0] lb_data0, lb_data2;
  logic        lb_valid0, lb_valid2;
  logic        ctr_valid0, ctr_valid2;
  logic [9:0]  ctr_row0, ctr_row2;
  logic [10:0] ctr_col0, ctr_col2;
  logic        busy0, busy2;
  logic        frame_done0, frame_done2;
  logic [1:0]  err0, err2;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  beat_t q0[$];
  beat_t q2[$];
  beat_t exp_q[$];
  int    t0[$];
  int    t2[$];
  int    fd0[$];
  int    fd2[$];

  img_window_ctrl #(.FLUSH_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height),
    .sof_i(sof_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .lb_data_o(lb_data0), .lb_valid_o(lb_valid0), .ctr_valid_o(ctr_valid0),
    .ctr_row_o(ctr_row0), .ctr_col_o(ctr_col0), .busy_o(busy0),
    .frame_done_o(frame_done0), .err_o(err0)
  );

  img_window_ctrl #(.FLUSH_GAP(2)) dut2 (
    .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height),
    .sof_i(sof_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .lb_data_o(lb_data2), .lb_valid_o(lb_valid2), .ctr_valid_o(ctr_valid2),
    .ctr_row_o(ctr_row2), .ctr_col_o(ctr_col2), .busy_o(busy2),
    .frame_done_o(frame_done2), .err_o(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset && lb_valid0) begin
      q0.push_back({lb_data0, ctr_valid0, ctr_row0, ctr_col0});
      t0.push_back(cyc);
    end
    if (reset && lb_valid2) begin
      q2.push_back({lb_data2, ctr_valid2, ctr_row2, ctr_col2});
      t2.push_back(cyc);
    end
    if (reset && frame_done0) fd0.push_back(cyc);
    if (reset && frame_done2) fd2.push_back(cyc);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic cyc_in(input logic s, input logic v, input logic [23:0] p);
    sof_i = s;
    pix_valid_i = v;
    pix_i = p;
    tick();
  endtask

  task automatic clear_logs;
    q0.delete(); q2.delete(); t0.delete(); t2.delete();
    fd0.delete(); fd2.delete(); exp_q.delete();
  endtask

  task automatic apply_reset;
    sof_i = 0; pix_valid_i = 0; pix_i = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic send_frame(input int w, input int h, input int base, input int n);
    img_width = 11'(w);
    img_height = 10'(h);
    for (int i = 0; i < n; i++) cyc_in(i == 0, 1'b1, 24'(base + i));
  endtask

  task automatic wait_fd(input int which, input int n);
    for (int k = 0; k < 200; k++) begin
      if ((which == 0 ? fd0.size() : fd2.size()) >= n) break;
      cyc_in(1'b0, 1'b0, '0);
    end
  endtask

  task automatic add_frame(input int w, input int base, input int first, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      int idx, row;
      idx = first + k;
      row = idx / w;
      b.d = 24'(base + k);
      b.cv = (row >= 1);
      b.r = 10'(row - 1);
      b.c = 11'(idx % w);
      exp_q.push_back(b);
    end
  endtask

  task automatic add_flush(input int w, input int h);
    beat_t b;
    for (int k = 0; k < w; k++) begin
      b.d = '0;
      b.cv = 1'b1;
      b.r = 10'(h - 1);
      b.c = 11'(k);
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(); tick();
    tests++;
    if (lb_valid0 !== 1'b0 || lb_data0 !== '0 || ctr_valid0 !== 1'b0) begin
      failed++;
      $display("FAIL reset_lb got v=%b d=%h cv=%b exp 0", lb_valid0, lb_data0, ctr_valid0);
    end
    tests++;
    if (ctr_row0 !== '0 || ctr_col0 !== '0) begin
      failed++;
      $display("FAIL reset_ctr got r=%0d c=%0d exp 0", ctr_row0, ctr_col0);
    end
    tests++;
    if (busy0 !== 1'b0 || frame_done0 !== 1'b0 || err0 !== 2'b00) begin
      failed++;
      $display("FAIL reset_status got busy=%b fd=%b err=%b exp 0", busy0, frame_done0, err0);
    end
    reset = 1'b1;
    tick();
    img_width = 11'd4;
    img_height = 10'd3;
    cyc_in(1'b0, 1'b1, 24'h55);
    cyc_in(1'b0, 1'b1, 24'h56);
    tests++;
    if (q0.size() !== 0 || busy0 !== 1'b0) begin
      failed++;
      $display("FAIL reset_no_sof got beats=%0d busy=%b exp 0", q0.size(), busy0);
    end
  endtask

  task automatic test_basic;
    int got;
    apply_reset(); clear_logs();
    send_frame(4, 3, 1, 12);
    cyc_in(1'b0, 1'b0, '0);
    wait_fd(0, 1);
    tests++;
    if (fd0.size() !== 1) begin
      failed++;
      $display("FAIL t1_done got %0d exp 1", fd0.size());
    end
    add_frame(4, 1, 0, 12);
    add_flush(4, 3);
    tests++;
    if (q0.size() !== exp_q.size()) begin
      failed++;
      $display("FAIL t1_count got %0d exp %0d", q0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
      tests++;
      if (q0[i].d !== exp_q[i].d || q0[i].cv !== exp_q[i].cv ||
          (exp_q[i].cv && (q0[i].r !== exp_q[i].r || q0[i].c !== exp_q[i].c))) begin
        failed++;
        $display("FAIL t1_beat[%0d] got d=%h cv=%b r=%0d c=%0d exp d=%h cv=%b r=%0d c=%0d",
                 i, q0[i].d, q0[i].cv, q0[i].r, q0[i].c,
                 exp_q[i].d, exp_q[i].cv, exp_q[i].r, exp_q[i].c);
      end
    end
    got = (t0.size() >= 16) ? t0[15] - t0[11] : -1;
    tests++;
    if (got != 4) begin
      failed++;
      $display("FAIL t1_flush_span got %0d exp 4", got);
    end
    got = (t0.size() >= 16 && fd0.size() >= 1) ? fd0[0] - t0[15] : -1;
    tests++;
    if (got != 1) begin
      failed++;
      $display("FAIL t1_done_delay got %0d exp 1", got);
    end
    tests++;
    if (err0 !== 2'b00 || busy0 !== 1'b0) begin
      failed++;
      $display("FAIL t1_status got err=%b busy=%b exp 00/0", err0, busy0);
    end
  endtask

  task automatic test_reset_flush;
    apply_reset(); clear_logs();
    send_frame(4, 3, 1, 12);
    cyc_in(1'b0, 1'b0, '0);
    tests++;
    if (lb_valid0 !== 1'b1 || busy0 !== 1'b1 || ctr_row0 !== 10'd2) begin
      failed++;
      $display("FAIL t2_in_flush got v=%b busy=%b r=%0d exp 1/1/2", lb_valid0, busy0, ctr_row0);
    end
    #1 reset = 1'b0;
    #1;
    tests++;
    if (lb_valid0 !== 1'b0 || ctr_valid0 !== 1'b0 || busy0 !== 1'b0 ||
        frame_done0 !== 1'b0 || ctr_row0 !== '0 || ctr_col0 !== '0 || lb_data0 !== '0) begin
      failed++;
      $display("FAIL t2_async_clear got v=%b cv=%b busy=%b fd=%b r=%0d exp all 0",
               lb_valid0, ctr_valid0, busy0, frame_done0, ctr_row0);
    end
    tick();
    reset = 1'b1;
    clear_logs();
    cyc_in(1'b0, 1'b0, '0);
    cyc_in(1'b0, 1'b0, '0);
    cyc_in(1'b0, 1'b0, '0);
    tests++;
    if (q0.size() !== 0 || busy0 !== 1'b0) begin
      failed++;
      $display("FAIL t2_idle_after got beats=%0d busy=%b exp 0/0", q0.size(), busy0);
    end
    send_frame(4, 3, 50, 12);
    cyc_in(1'b0, 1'b0, '0);
    wait_fd(0, 1);
    add_frame(4, 50, 0, 12);
    add_flush(4, 3);
    tests++;
    if (q0.size() !== exp_q.size() || fd0.size() !== 1) begin
      failed++;
      $display("FAIL t2_count got beats=%0d fd=%0d exp %0d/1", q0.size(), fd0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
      tests++;
      if (q0[i].d !== exp_q[i].d || q0[i].cv !== exp_q[i].cv ||
          (exp_q[i].cv && (q0[i].r !== exp_q[i].r || q0[i].c !== exp_q[i].c))) begin
        failed++;
        $display("FAIL t2_beat[%0d] got d=%h cv=%b r=%0d c=%0d exp d=%h cv=%b r=%0d c=%0d",
                 i, q0[i].d, q0[i].cv, q0[i].r, q0[i].c,
                 exp_q[i].d, exp_q[i].cv, exp_q[i].r, exp_q[i].c);
      end
    end
    tests++;
    if (err0 !== 2'b00) begin
      failed++;
      $display("FAIL t2_err got %b exp 00", err0);
    end
  endtask

  task automatic test_short_frame;
    apply_reset(); clear_logs();
    send_frame(4, 3, 1, 6);
    send_frame(4, 3, 101, 12);
    cyc_in(1'b0, 1'b0, '0);
    wait_fd(0, 1);
    add_frame(4, 1, 0, 6);
    add_frame(4, 101, 0, 12);
    add_flush(4, 3);
    tests++;
    if (err0 !== 2'b01) begin
      failed++;
      $display("FAIL t3_err got %b exp 01", err0);
    end
    tests++;
    if (q0.size() !== exp_q.size() || fd0.size() !== 1) begin
      failed++;
      $display("FAIL t3_count got beats=%0d fd=%0d exp %0d/1", q0.size(), fd0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
      tests++;
      if (q0[i].d !== exp_q[i].d || q0[i].cv !== exp_q[i].cv ||
          (exp_q[i].cv && (q0[i].r !== exp_q[i].r || q0[i].c !== exp_q[i].c))) begin
        failed++;
        $display("FAIL t3_beat[%0d] got d=%h cv=%b r=%0d c=%0d exp d=%h cv=%b r=%0d c=%0d",
                 i, q0[i].d, q0[i].cv, q0[i].r, q0[i].c,
                 exp_q[i].d, exp_q[i].cv, exp_q[i].r, exp_q[i].c);
      end
    end
  endtask

  task automatic test_flush_drop;
    int got;
    apply_reset(); clear_logs();
    send_frame(4, 3, 1, 12);
    cyc_in(1'b0, 1'b1, 24'hBAD0);
    cyc_in(1'b1, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      if (frame_done0 === 1'b1) break;
      cyc_in(1'b0, 1'b0, '0);
    end
    tests++;
    if (frame_done0 !== 1'b1 || busy0 !== 1'b1) begin
      failed++;
      $display("FAIL t4_done_to_run got fd=%b busy=%b exp 1/1", frame_done0, busy0);
    end
    for (int i = 0; i < 12; i++) cyc_in(1'b0, 1'b1, 24'(201 + i));
    cyc_in(1'b0, 1'b0, '0);
    wait_fd(0, 2);
    add_frame(4, 1, 0, 12);
    add_flush(4, 3);
    add_frame(4, 201, 0, 12);
    add_flush(4, 3);
    tests++;
    if (err0 !== 2'b10) begin
      failed++;
      $display("FAIL t4_err got %b exp 10", err0);
    end
    tests++;
    if (q0.size() !== exp_q.size() || fd0.size() !== 2) begin
      failed++;
      $display("FAIL t4_count got beats=%0d fd=%0d exp %0d/2", q0.size(), fd0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
      tests++;
      if (q0[i].d !== exp_q[i].d || q0[i].cv !== exp_q[i].cv ||
          (exp_q[i].cv && (q0[i].r !== exp_q[i].r || q0[i].c !== exp_q[i].c))) begin
        failed++;
        $display("FAIL t4_beat[%0d] got d=%h cv=%b r=%0d c=%0d exp d=%h cv=%b r=%0d c=%0d",
                 i, q0[i].d, q0[i].cv, q0[i].r, q0[i].c,
                 exp_q[i].d, exp_q[i].cv, exp_q[i].r, exp_q[i].c);
      end
    end
    got = (t0.size() >= 17 && fd0.size() >= 1) ? t0[16] - fd0[0] : -1;
    tests++;
    if (got != 1) begin
      failed++;
      $display("FAIL t4_no_idle got %0d exp 1", got);
    end
  endtask

  task automatic test_zero_height;
    clear_logs();
    img_width = 11'd4;
    img_height = 10'd0;
    for (int k = 0; k < 4; k++) begin
      cyc_in(k == 0, 1'b1, 24'(7 + k));
      tests++;
      if (busy0 !== 1'b0) begin
        failed++;
        $display("FAIL t6_busy[%0d] got %b exp 0", k, busy0);
      end
    end
    cyc_in(1'b0, 1'b0, '0);
    cyc_in(1'b0, 1'b0, '0);
    tests++;
    if (q0.size() !== 0) begin
      failed++;
      $display("FAIL t6_beats got %0d exp 0", q0.size());
    end
    tests++;
    if (err0 !== 2'b10) begin
      failed++;
      $display("FAIL t6_err got %b exp 10", err0);
    end
  endtask

  task automatic test_gap;
    int got;
    apply_reset(); clear_logs();
    send_frame(5, 1, 1, 5);
    cyc_in(1'b0, 1'b0, '0);
    wait_fd(2, 1);
    add_frame(5, 1, 0, 5);
    add_flush(5, 1);
    tests++;
    if (q2.size() !== exp_q.size() || fd2.size() !== 1) begin
      failed++;
      $display("FAIL t5_count got beats=%0d fd=%0d exp %0d/1", q2.size(), fd2.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q2.size(); i++) begin
      tests++;
      if (q2[i].d !== exp_q[i].d || q2[i].cv !== exp_q[i].cv ||
          (exp_q[i].cv && (q2[i].r !== exp_q[i].r || q2[i].c !== exp_q[i].c))) begin
        failed++;
        $display("FAIL t5_beat[%0d] got d=%h cv=%b r=%0d c=%0d exp d=%h cv=%b r=%0d c=%0d",
                 i, q2[i].d, q2[i].cv, q2[i].r, q2[i].c,
                 exp_q[i].d, exp_q[i].cv, exp_q[i].r, exp_q[i].c);
      end
    end
    got = (t2.size() >= 6) ? t2[5] - t2[4] : -1;
    tests++;
    if (got != 1) begin
      failed++;
      $display("FAIL t5_first_flush got %0d exp 1", got);
    end
    for (int i = 6; i < 10; i++) begin
      got = (t2.size() > i) ? t2[i] - t2[i-1] : -1;
      tests++;
      if (got != 3) begin
        failed++;
        $display("FAIL t5_spacing[%0d] got %0d exp 3", i, got);
      end
    end
    got = (t2.size() >= 10 && fd2.size() >= 1) ? fd2[0] - t2[9] : -1;
    tests++;
    if (got != 1) begin
      failed++;
      $display("FAIL t5_done_delay got %0d exp 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_flush();
    test_short_frame();
    test_flush_drop();
    test_zero_height();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
